// File: rtl/edgedet_pkg.sv
// edgedet_pkg: shared frame geometry, FSM states and divide-by-3 reciprocal constants
package edgedet_pkg;
    localparam int IMG_WIDTH = 720;
    localparam int IMG_HEIGHT = 576;
    localparam int IROW_WIDTH = 10;
    localparam int ICOL_WIDTH = 10;
    localparam logic [9:0] RECIP3 = 10'd683;
    localparam int RECIP3_SHIFT = 11;
    typedef enum logic {S_EMPTY, S_FULL} state_t;
endpackage

// File: rtl/gray_stream_if.sv
// gray_stream_if: upstream FIFO read side, downstream FIFO write side and frame status
interface gray_stream_if;
    logic in_empty;
    logic [23:0] in_dout;
    logic in_rd_en;
    logic out_full;
    logic out_wr_en;
    logic [7:0] out_din;
    logic frame_done;
    logic [15:0] frame_cnt;
    modport master (
        input in_empty, in_dout, out_full,
        output in_rd_en, out_wr_en, out_din, frame_done, frame_cnt
    );
    modport slave (
        output in_empty, in_dout, out_full,
        input in_rd_en, out_wr_en, out_din, frame_done, frame_cnt
    );
endinterface

// File: rtl/gray_stream_div3.sv
// gray_div3: RGB to gray as floor((R+G+B)/3) via a reciprocal multiply
module gray_div3
    import edgedet_pkg::*;
(
    input  logic [23:0] rgb,
    output logic [7:0]  gray
);
    logic [9:0] sum;
    logic [19:0] prod;
    // 683/2048 is exact for floor(sum/3) over the whole 0..765 range
    always_comb begin
        sum = 10'(rgb[23:16]) + 10'(rgb[15:8]) + 10'(rgb[7:0]);
        prod = 20'(sum) * 20'(RECIP3);
        gray = 8'(prod >> RECIP3_SHIFT);
    end
endmodule

// File: rtl/gray_stream.sv
// gray_stream: FIFO-to-FIFO grayscale converter with a one-entry holding register and raster counters
module gray_stream
    import edgedet_pkg::*;
#(
    parameter int IMG_WIDTH = edgedet_pkg::IMG_WIDTH,
    parameter int IMG_HEIGHT = edgedet_pkg::IMG_HEIGHT,
    parameter int IROW_WIDTH = edgedet_pkg::IROW_WIDTH,
    parameter int ICOL_WIDTH = edgedet_pkg::ICOL_WIDTH
) (
    input logic clk,
    input logic rst_n,
    gray_stream_if.master bus
);
    state_t state;
    logic [7:0] hold;
    logic [7:0] gray;
    logic [IROW_WIDTH-1:0] irow;
    logic [ICOL_WIDTH-1:0] icol;
    logic frame_done;
    logic [15:0] frame_cnt;
    logic rd, wr;
    gray_div3 u_div3 (.rgb(bus.in_dout), .gray(gray));
    assign rd = rst_n & ~bus.in_empty & ((state == S_EMPTY) | ~bus.out_full);
    assign wr = (state == S_FULL) & ~bus.out_full;
    assign bus.in_rd_en = rd;
    assign bus.out_wr_en = wr;
    assign bus.out_din = hold;
    assign bus.frame_done = frame_done;
    assign bus.frame_cnt = frame_cnt;
    // holding register: any pop reloads it, a push without a pop empties it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_EMPTY;
            hold <= 8'd0;
        end else if (rd) begin
            state <= S_FULL;
            hold <= gray;
        end else if (wr) begin
            state <= S_EMPTY;
        end
    end
    // raster position advances per pushed pixel; last pixel of a frame wraps and flags completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irow <= '0;
            icol <= '0;
            frame_done <= 1'b0;
            frame_cnt <= 16'd0;
        end else begin
            frame_done <= 1'b0;
            if (wr) begin
                if (icol == ICOL_WIDTH'(IMG_WIDTH - 1)) begin
                    icol <= '0;
                    if (irow == IROW_WIDTH'(IMG_HEIGHT - 1)) begin
                        irow <= '0;
                        frame_done <= 1'b1;
                        frame_cnt <= frame_cnt + 16'd1;
                    end else begin
                        irow <= irow + 1'b1;
                    end
                end else begin
                    icol <= icol + 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/gray_stream.md
# gray_stream

Producer stage feeding the edge-detect filter's input FIFO. Pops 24-bit RGB pixels from an upstream FWFT FIFO, converts each to 8-bit grayscale as the exact integer floor((R+G+B)/3), and pushes it into the downstream FIFO. Runs at one pixel per cycle with a one-entry output register. Keeps raster row/column counters so downstream stages can be checked against a frame-done pulse and a frame counter.

## Interface
- IMG_WIDTH, 720, pixels per row
- IMG_HEIGHT, 576, rows per frame
- IROW_WIDTH, 10, row counter width
- ICOL_WIDTH, 10, column counter width
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- in_empty  in  1  upstream FIFO empty
- in_dout  in  24  upstream pixel {R[23:16], G[15:8], B[7:0]}, valid when in_empty=0
- in_rd_en  out  1  pop upstream FIFO this cycle
- out_full  in  1  downstream FIFO full
- out_wr_en  out  1  push out_din this cycle
- out_din  out  8  gray pixel
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is pushed
- frame_cnt  out  16  completed frames, wraps at 2^16

## Operation
- FSM state_t: S_EMPTY (holding register invalid), S_FULL (holding register holds a gray pixel).
- in_rd_en = ~in_empty & (state==S_EMPTY | ~out_full). It is forced 0 while rst_n is low.
- out_wr_en = (state==S_FULL) & ~out_full. out_din is driven from the holding register.
- Transitions:
  - S_EMPTY: pop, load register, go to S_FULL. No pop, stay in S_EMPTY.
  - S_FULL: push and pop together, reload register, stay in S_FULL. Push only, go to S_EMPTY. No push, hold; in_rd_en stays 0.
- Arithmetic:
  - sum = R+G+B, 10 bits, max 765.
  - gray = (sum*683)>>11. The product is 20 bits. The result is exactly floor(sum/3) over 0..765 and is never above 255, so no saturation logic.
- Counters icol and irow advance on each push (out_wr_en=1), not on each pop.
  - When icol reaches IMG_WIDTH-1, icol wraps to 0 and irow increments.
  - On the push of the pixel at (IMG_HEIGHT-1, IMG_WIDTH-1):
    - irow and icol both return to 0.
    - frame_done is high the following cycle, for exactly one cycle.
    - frame_cnt increments on that same edge.
- No frame-start sync exists. Frames are delimited purely by pixel count.

## Timing
- Reset values: state=S_EMPTY, out_din=0, out_wr_en=0, in_rd_en=0, frame_done=0, frame_cnt=0, irow=0, icol=0.
- Latency: a pixel popped in cycle N is presented with out_wr_en=1 in cycle N+1, provided out_full=0.
- Sustained throughput is 1 pixel/cycle while in_empty=0 and out_full=0.
- Backpressure: if out_full is asserted while in S_FULL, the register and out_din hold. No pixel is dropped or duplicated. Output order equals input order.
- Simultaneous push and pop in S_FULL: the register takes the new pixel on the same edge that the old pixel is accepted.
- Reset mid-frame:
  - All state clears immediately, asynchronously.
  - A pixel held in the register is discarded.
  - The next pushed pixel counts as (0,0).
- in_empty and out_full may toggle every cycle. Outputs depend only on current state and those inputs; there are no combinational loops through in_dout.

## Structure
- edgedet_pkg holds:
  - default IMG_WIDTH, IMG_HEIGHT, IROW_WIDTH, ICOL_WIDTH;
  - state_t;
  - RECIP3=683 and RECIP3_SHIFT=11.
- The sobel stage and other pipeline stages import this package.
- Sub-module gray_div3: purely combinational, 24-bit RGB in, 8-bit gray out (sum plus reciprocal multiply). It is unit-tested exhaustively over sum 0..765.
- The top module contains the FSM, holding register, counters and the frame_done/frame_cnt registers.

## Test plan
- Single pixel 24'hFFFFFF, out_full=0 -> out_din=8'hFF with out_wr_en=1 exactly one cycle after in_rd_en; nothing further.
- Arithmetic set, streamed back to back -> out_din sequence 0x14, 0x00, 0xFE, 0x00, 0x55:
  - {10,20,30}
  - {1,1,0}
  - {FF,FF,FE}
  - {0,0,0}
  - {FF,0,0}
- Continuous stream of 20 distinct pixels with out_full high for cycles 4-8 -> in_rd_en=0 during the stall; all 20 outputs present in order, none duplicated; 1 px/cycle before and after.
- IMG_WIDTH=4, IMG_HEIGHT=3, two 12-pixel frames with random in_empty gaps:
  - frame_done pulses once, the cycle after the 12th and again the cycle after the 24th push;
  - frame_cnt reads 1, then 2;
  - out_wr_en only ever high for real pixels.
- Reset mid-frame (IMG_WIDTH=4, IMG_HEIGHT=3): drop rst_n after 5 pushes with one pixel held -> all outputs 0 immediately, held pixel never pushed; 12 further pixels then yield exactly one frame_done and frame_cnt=1.
- Upstream empty throughout -> in_rd_en and out_wr_en stay 0, counters stay 0.
